// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Serial receiver. It recovers frames laid out as start(0),
//             even parity, data[0..7] LSB first, stop(1), with each bit
//             lasting clksPerBit clocks. The byte is delivered with a
//             one-cycle valid strobe plus parity and framing status.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int clksPerBit = 87            // legal 4..65535, must match transmitter
) (
    input  logic       i_clkRx,
    input  logic       i_rstNRx,
    input  logic       i_dataRx,
    output logic [7:0] o_bitsRx,
    output logic       o_validRx,
    output logic       o_parityErrRx,
    output logic       o_frameErrRx,
    output logic       o_busyRx
);

    // Last count of a bit period, and the half-bit point used to find mid-start.
    localparam logic [15:0] c_lastCnt = 16'(clksPerBit - 1);
    localparam logic [15:0] c_halfCnt = 16'((clksPerBit - 1) / 2);

    typedef enum logic [2:0] {
        s_idleRx   = 3'd0,
        s_startRx  = 3'd1,
        s_parityRx = 3'd2,
        s_dataRx   = 3'd3,
        s_stopRx   = 3'd4,
        s_breakRx  = 3'd5
    } rxState_t;

    // Synchronizer and receiver state
    logic       r_rxMeta;
    logic       r_rxS;
    rxState_t   r_state;
    logic [15:0] r_clkCnt;
    logic [2:0] r_bitIdx;
    logic       r_parity;
    logic [7:0] r_data;

    // Next-state / control decoded from the current state
    rxState_t   w_stateNext;
    logic [15:0] w_cntNext;
    logic [2:0] w_idxNext;
    logic       w_latchParity;
    logic       w_latchData;
    logic       w_accept;
    logic       w_frameErr;

    // Two-flop synchronizer; both flops rest at the idle-line level.
    always_ff @(posedge i_clkRx or negedge i_rstNRx) begin
        if (!i_rstNRx) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
        end else begin
            r_rxMeta <= i_dataRx;
            r_rxS    <= r_rxMeta;
        end
    end

    // State register.
    always_ff @(posedge i_clkRx or negedge i_rstNRx) begin
        if (!i_rstNRx) begin
            r_state <= s_idleRx;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and sampling control. Samples are taken at the last count
    // of each bit period, which lands one full period after the mid-start point.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_clkCnt;
        w_idxNext     = r_bitIdx;
        w_latchParity = 1'b0;
        w_latchData   = 1'b0;
        w_accept      = 1'b0;
        w_frameErr    = 1'b0;

        case (r_state)
            s_idleRx: begin
                w_cntNext = 16'd0;
                if (!r_rxS) begin
                    w_stateNext = s_startRx;
                end
            end

            s_startRx: begin
                if (r_clkCnt == c_halfCnt) begin
                    w_cntNext = 16'd0;
                    // A line already back high at mid-start was only a glitch.
                    w_stateNext = r_rxS ? s_idleRx : s_parityRx;
                end else begin
                    w_cntNext = r_clkCnt + 16'd1;
                end
            end

            s_parityRx: begin
                if (r_clkCnt == c_lastCnt) begin
                    w_cntNext     = 16'd0;
                    w_latchParity = 1'b1;
                    w_idxNext     = 3'd0;
                    w_stateNext   = s_dataRx;
                end else begin
                    w_cntNext = r_clkCnt + 16'd1;
                end
            end

            s_dataRx: begin
                if (r_clkCnt == c_lastCnt) begin
                    w_cntNext   = 16'd0;
                    w_latchData = 1'b1;
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = s_stopRx;
                    end else begin
                        w_idxNext = r_bitIdx + 3'd1;
                    end
                end else begin
                    w_cntNext = r_clkCnt + 16'd1;
                end
            end

            s_stopRx: begin
                if (r_clkCnt == c_lastCnt) begin
                    w_cntNext = 16'd0;
                    // Return to idle at mid-stop so a zero-gap next frame is not missed.
                    if (r_rxS) begin
                        w_accept    = 1'b1;
                        w_stateNext = s_idleRx;
                    end else begin
                        w_frameErr  = 1'b1;
                        w_stateNext = s_breakRx;
                    end
                end else begin
                    w_cntNext = r_clkCnt + 16'd1;
                end
            end

            s_breakRx: begin
                // Park here while the line is held low so a break reports once.
                w_cntNext = 16'd0;
                if (r_rxS) begin
                    w_stateNext = s_idleRx;
                end
            end

            default: begin
                w_cntNext   = 16'd0;
                w_stateNext = s_idleRx;
            end
        endcase
    end

    // Bit-period counter, bit index and the shift/parity capture registers.
    always_ff @(posedge i_clkRx or negedge i_rstNRx) begin
        if (!i_rstNRx) begin
            r_clkCnt <= 16'd0;
            r_bitIdx <= 3'd0;
            r_parity <= 1'b0;
            r_data   <= 8'd0;
        end else begin
            r_clkCnt <= w_cntNext;
            r_bitIdx <= w_idxNext;
            if (w_latchParity) begin
                r_parity <= r_rxS;
            end
            if (w_latchData) begin
                r_data[r_bitIdx] <= r_rxS;
            end
        end
    end

    // Output registers: byte and parity status move only on an accepted frame.
    always_ff @(posedge i_clkRx or negedge i_rstNRx) begin
        if (!i_rstNRx) begin
            o_bitsRx      <= 8'd0;
            o_validRx     <= 1'b0;
            o_parityErrRx <= 1'b0;
            o_frameErrRx  <= 1'b0;
        end else begin
            o_validRx    <= w_accept;
            o_frameErrRx <= w_frameErr;
            if (w_accept) begin
                o_bitsRx      <= r_data;
                o_parityErrRx <= (^r_data) ^ r_parity;
            end
        end
    end

    assign o_busyRx = (r_state != s_idleRx);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. The whole line waveform is
//             built up front, decoded by a frame-level model into per-cycle
//             expected outputs, then replayed into the receiver.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int H    = (CPB - 1) / 2;
    localparam int MAXN = 16384;

    logic       clk = 1'b0;
    logic       rstN;
    logic       dataIn;
    logic [7:0] bitsOut;
    logic       validOut;
    logic       perrOut;
    logic       ferrOut;
    logic       busyOut;

    always #5 clk = ~clk;

    uart_rx #(.clksPerBit(CPB)) dut (
        .i_clkRx      (clk),
        .i_rstNRx     (rstN),
        .i_dataRx     (dataIn),
        .o_bitsRx     (bitsOut),
        .o_validRx    (validOut),
        .o_parityErrRx(perrOut),
        .o_frameErrRx (ferrOut),
        .o_busyRx     (busyOut)
    );

    // Stimulus, one entry per rising clock edge
    bit lineA [MAXN];
    bit rstA  [MAXN];
    int nLen = 0;

    // Expected outputs, one entry per rising clock edge
    bit         eValid [MAXN];
    bit         eFerr  [MAXN];
    bit         eBusy  [MAXN];
    bit         eUpd   [MAXN];
    logic [7:0] eUpdByte [MAXN];
    bit         eUpdPerr [MAXN];
    logic [7:0] eBits  [MAXN];
    bit         ePerr  [MAXN];

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int         n;
        string      nm;
        int         which;   // 0 valid, 1 bits, 2 parity err, 3 frame err, 4 busy
        logic [7:0] val;
    } pin_t;
    pin_t pins[$];

    task automatic chk(input string nm, input int n, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, n, act, exp);
        end
    endtask

    task automatic push(input bit v, input int k);
        for (int i = 0; i < k; i++) begin
            if (nLen < MAXN) begin
                lineA[nLen] = v;
                rstA[nLen]  = 1'b0;
                nLen++;
            end
        end
    endtask

    task automatic pushFrame(input logic [7:0] b, input bit badPar, input bit stopV, input int stopLen);
        push(1'b0, CPB);
        push((^b) ^ badPar, CPB);
        for (int i = 0; i < 8; i++) push(b[i], CPB);
        push(stopV, stopLen);
    endtask

    task automatic addPin(input int n, input string nm, input int which, input logic [7:0] val);
        pin_t p;
        p.n = n; p.nm = nm; p.which = which; p.val = val;
        pins.push_back(p);
    endtask

    // Line level the receiver decides on at edge n: two clocks of
    // synchronizer delay, forced high while the synchronizer is in reset.
    function automatic bit sOf(input int n);
        if (n < 2 || n - 2 >= nLen) return 1'b1;
        if (rstA[n - 2]) return 1'b1;
        if (n - 1 < nLen && rstA[n - 1]) return 1'b1;
        return lineA[n - 2];
    endfunction

    function automatic int firstReset(input int a, input int b);
        for (int i = a; i <= b && i < nLen; i++) begin
            if (rstA[i]) return i;
        end
        return -1;
    endfunction

    task automatic markBusy(input int a, input int b);
        for (int i = a; i <= b && i < nLen; i++) eBusy[i] = 1'b1;
    endtask

    // Frame-level decode: find a start, check mid-start, take ten samples
    // spaced one bit period apart, classify by the stop sample.
    task automatic runModel();
        int t, mid, fin, r, e;
        bit good, p, curP;
        logic [7:0] d, cur;
        for (int n = 0; n < nLen; n++) begin
            eValid[n] = 0; eFerr[n] = 0; eBusy[n] = 0; eUpd[n] = 0;
        end
        t = 0;
        while (t < nLen) begin
            if (rstA[t] || sOf(t)) begin
                t++;
                continue;
            end
            mid  = t + 1 + H;
            good = 1'b0;
            d    = 8'd0;
            p    = 1'b0;
            if (sOf(mid)) begin
                fin = mid;
            end else begin
                p = sOf(mid + CPB);
                for (int i = 0; i < 8; i++) d[i] = sOf(mid + (2 + i) * CPB);
                fin  = mid + 10 * CPB;
                good = 1'b1;
            end
            r = firstReset(t + 1, fin);
            if (r >= 0) begin
                markBusy(t, r - 1);
                t = r;
                continue;
            end
            if (fin >= nLen) begin
                markBusy(t, nLen - 1);
                break;
            end
            markBusy(t, fin - 1);
            if (!good) begin
                t = fin + 1;
            end else if (sOf(fin)) begin
                eValid[fin]   = 1'b1;
                eUpd[fin]     = 1'b1;
                eUpdByte[fin] = d;
                eUpdPerr[fin] = (^d) ^ p;
                t = fin + 1;
            end else begin
                eFerr[fin] = 1'b1;
                eBusy[fin] = 1'b1;
                e = fin + 1;
                while (e < nLen && !rstA[e] && !sOf(e)) begin
                    eBusy[e] = 1'b1;
                    e++;
                end
                t = (e < nLen && rstA[e]) ? e : e + 1;
            end
        end
        cur  = 8'd0;
        curP = 1'b0;
        for (int n = 0; n < nLen; n++) begin
            if (rstA[n]) begin
                cur = 8'd0; curP = 1'b0;
            end else if (eUpd[n]) begin
                cur = eUpdByte[n]; curP = eUpdPerr[n];
            end
            eBits[n] = cur;
            ePerr[n] = curP;
        end
    endtask

    function automatic logic [7:0] outSel(input int w);
        case (w)
            0:       return {7'd0, validOut};
            1:       return bitsOut;
            2:       return {7'd0, perrOut};
            3:       return {7'd0, ferrOut};
            default: return {7'd0, busyOut};
        endcase
    endfunction

    initial begin
        int la, l01, lg, l3c, l5a, lf, ra, l81, lb, lr, cntV, cntF, k, g;
        rstN   = 1'b0;
        dataIn = 1'b1;

        // Power-up reset, then idle
        push(1'b1, 24);
        for (int i = 0; i < 4; i++) rstA[i] = 1'b1;

        // 0xA5 with correct parity
        la = nLen;  pushFrame(8'hA5, 1'b0, 1'b1, CPB); push(1'b1, 10);
        // 0x01 with parity bit forced wrong
        l01 = nLen; pushFrame(8'h01, 1'b1, 1'b1, CPB); push(1'b1, 10);
        // Short low glitch in idle
        lg = nLen;  push(1'b0, 4); push(1'b1, 40);
        // 0x3C with bad stop and a 50 bit-period break, then 0x5A
        l3c = nLen; pushFrame(8'h3C, 1'b0, 1'b0, CPB); push(1'b0, 50 * CPB); push(1'b1, 20);
        l5a = nLen; pushFrame(8'h5A, 1'b0, 1'b1, CPB); push(1'b1, 20);
        // 0xFF aborted by reset mid-data, then 0x81
        lf = nLen;  pushFrame(8'hFF, 1'b0, 1'b1, CPB); push(1'b1, 40);
        ra = lf + 4 * CPB + 5;
        for (int i = 0; i < 3; i++) rstA[ra + i] = 1'b1;
        l81 = nLen; pushFrame(8'h81, 1'b0, 1'b1, CPB); push(1'b1, 20);
        // Transmitter-style back-to-back frames, stop stretched one clock
        lb = nLen;
        pushFrame(8'h00, 1'b0, 1'b1, CPB + 1);
        pushFrame(8'hFF, 1'b0, 1'b1, CPB + 1);
        pushFrame(8'h3C, 1'b0, 1'b1, CPB + 1);
        push(1'b1, 30);

        // Randomized traffic
        lr = nLen;
        for (int j = 0; j < 25; j++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                g = $urandom_range(1, 6);
                push(1'b0, g); push(1'b1, $urandom_range(12, 30));
            end else if (k == 1) begin
                pushFrame(8'($urandom_range(0, 255)), 1'b0, 1'b0, CPB);
                push(1'b0, $urandom_range(0, 6 * CPB));
                push(1'b1, $urandom_range(20, 40));
            end else begin
                pushFrame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0),
                          1'b1, CPB + $urandom_range(0, 4));
                push(1'b1, $urandom_range(0, 20));
            end
        end
        push(1'b1, 2 * CPB);

        runModel();

        // Hand-derived expectations that pin the model: valid lands 2 sync
        // clocks + H+1 + 10 bit periods after the line first drops.
        chk("model_A5_valid", la + 170, {7'd0, eValid[la + 170]}, 8'd1);
        chk("model_A5_byte", la + 170, eUpdByte[la + 170], 8'hA5);
        chk("model_01_perr", l01 + 170, {7'd0, eUpdPerr[l01 + 170]}, 8'd1);
        chk("model_3C_ferr", l3c + 170, {7'd0, eFerr[l3c + 170]}, 8'd1);
        cntV = 0; cntF = 0;
        for (int n = 0; n < lr; n++) begin
            cntV += int'(eValid[n]);
            cntF += int'(eFerr[n]);
        end
        chk("model_directed_valids", lr, 8'(cntV), 8'd7);
        chk("model_directed_ferrs", lr, 8'(cntF), 8'd1);

        // Literal expectations checked directly against the receiver
        addPin(la + 169, "A5_early", 0, 8'd0);
        addPin(la + 170, "A5_valid", 0, 8'd1);
        addPin(la + 170, "A5_bits", 1, 8'hA5);
        addPin(la + 170, "A5_perr", 2, 8'd0);
        addPin(la + 171, "A5_pulse_end", 0, 8'd0);
        addPin(l01 + 170, "01_bits", 1, 8'h01);
        addPin(l01 + 170, "01_perr", 2, 8'd1);
        addPin(lg + 2, "glitch_busy", 4, 8'd1);
        addPin(lg + 2 + 1 + H, "glitch_idle", 4, 8'd0);
        addPin(l3c + 170, "3C_ferr", 3, 8'd1);
        addPin(l3c + 170, "3C_novalid", 0, 8'd0);
        addPin(l3c + 170, "3C_bits_held", 1, 8'h01);
        addPin(l3c + 171, "3C_ferr_once", 3, 8'd0);
        addPin(l5a + 170, "5A_bits", 1, 8'h5A);
        addPin(ra + 1, "rst_bits", 1, 8'd0);
        addPin(ra + 1, "rst_busy", 4, 8'd0);
        addPin(l81 + 170, "81_bits", 1, 8'h81);
        addPin(lb + 170, "lb0_bits", 1, 8'h00);
        addPin(lb + 170, "lb0_valid", 0, 8'd1);
        addPin(lb + 177 + 170, "lb1_bits", 1, 8'hFF);
        addPin(lb + 354 + 170, "lb2_bits", 1, 8'h3C);
        addPin(lb + 354 + 170, "lb2_perr", 2, 8'd0);

        // Replay: drive on the falling edge, check just after the rising edge
        for (int n = 0; n < nLen; n++) begin
            @(negedge clk);
            dataIn = lineA[n];
            rstN   = ~rstA[n];
            @(posedge clk);
            #1;
            chk("valid", n, {7'd0, validOut}, {7'd0, eValid[n]});
            chk("frameErr", n, {7'd0, ferrOut}, {7'd0, eFerr[n]});
            chk("busy", n, {7'd0, busyOut}, {7'd0, eBusy[n]});
            chk("bits", n, bitsOut, eBits[n]);
            chk("parityErr", n, {7'd0, perrOut}, {7'd0, ePerr[n]});
            foreach (pins[i]) begin
                if (pins[i].n == n) chk(pins[i].nm, n, outSel(pins[i].which), pins[i].val);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive stage that consumes the serial line driven by uart_tx.
- Recovers one frame in this order, one bit each, at clksPerBit clocks per bit: start(0), even-parity bit (XOR of the 8 data bits), data bits 0..7 LSB first, stop(1).
- Delivers the byte with a one-cycle valid strobe and parity/framing status to the downstream consumer.

Parameters:
- clksPerBit, 87, clocks per bit period (legal 4..65535; must match the transmitter).

Ports:
- i_clkRx  in  1  receive clock.
- i_rstNRx  in  1  asynchronous active-low reset.
- i_dataRx  in  1  serial line, asynchronous to i_clkRx, idles high.
- o_bitsRx  out  8  received byte; held until the next accepted frame.
- o_validRx  out  1  one-cycle pulse: o_bitsRx/o_parityErrRx updated, stop bit good.
- o_parityErrRx  out  1  parity status of the last accepted frame; changes only with o_validRx.
- o_frameErrRx  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- o_busyRx  out  1  high whenever state is not s_idleRx.

Behaviour:
- Reset:
  - Asynchronous, active-low, effective immediately, including mid-frame.
  - o_bitsRx=0, o_validRx=0, o_parityErrRx=0, o_frameErrRx=0, o_busyRx=0.
  - Synchronizer flops=1, counters=0, state=s_idleRx.
  - After release, a partially received frame is not recovered; the next falling edge starts a new frame.
- Input sync: 2-flop synchronizer on i_dataRx, both flops reset to 1. All decisions use the second flop, rxS.
- Counters:
  - Clock counter is 16 bits and counts 0..clksPerBit-1.
  - Bit index is 3 bits and counts 0..7.
  - H = (clksPerBit-1)/2, integer division.
- s_idleRx: counter=0. rxS==0 -> s_startRx.
- s_startRx: count to H.
  - At counter==H, if rxS==1 (glitch), go to s_idleRx with no output.
  - Otherwise clear the counter and go to s_parityRx. This point is the mid-start reference; every later sample is exactly clksPerBit clocks after the previous one.
- s_parityRx: at counter==clksPerBit-1, latch rxS into the parity register, clear the counter, set bit index=0, go to s_dataRx.
- s_dataRx:
  - At each counter==clksPerBit-1, shift rxS into data bit [index].
  - Index 7 -> s_stopRx. Otherwise index+1.
- s_stopRx: at counter==clksPerBit-1, sample rxS.
  - rxS==1: on the next clock edge load o_bitsRx, set o_parityErrRx = (^data) XOR parity, pulse o_validRx, go to s_idleRx. Return to idle is immediate at mid-stop; the remaining half stop bit is not waited out.
  - rxS==0: pulse o_frameErrRx, leave o_bitsRx/o_parityErrRx unchanged, go to s_breakRx.
- s_breakRx: wait until rxS==1, then go to s_idleRx. A held-low line (break) produces exactly one o_frameErrRx, not repeated frames.
- Latency: mid-stop sample occurs 10*clksPerBit clocks after the mid-start sample; o_validRx follows one clock later.
- Tolerance:
  - Stop bits longer than one bit period are accepted; the transmitter stretches its stop by one clock.
  - Back-to-back frames with zero idle gap are received without loss.
- Parity error does not suppress o_validRx; the consumer decides.
- o_validRx and o_frameErrRx are never high in the same cycle.
- Line glitches shorter than H clocks in idle produce no output.

Test Plan (clksPerBit=16, H=7, bit period 16 clocks):
- Frame 0xA5: line 0,0,1,0,1,0,0,1,0,1,1 -> one o_validRx pulse, o_bitsRx=0xA5, o_parityErrRx=0, o_frameErrRx never high.
- Frame 0x01 with parity bit forced 0 (correct is 1) -> o_validRx pulse, o_bitsRx=0x01, o_parityErrRx=1.
- Line low for 4 clocks, then high -> o_busyRx high for about 7 clocks, then 0; no o_validRx, no o_frameErrRx.
- Frame 0x3C with stop bit 0 and line held low 50 bit periods -> exactly one o_frameErrRx pulse, o_bitsRx unchanged from previous; after the line returns high, frame 0x5A is received correctly.
- Reset asserted mid-data of frame 0xFF, released 3 clocks later while the line keeps toggling, then frame 0x81 -> all outputs 0 during reset, no output for the aborted frame, then 0x81 received.
- Loopback from uart_tx (clksPerBit=16) sending 0x00, 0xFF, 0x3C back to back -> three o_validRx pulses with matching bytes, all o_parityErrRx=0.
